// File: rtl/div_issue_ctrl_if.sv
// Pipeline-side handshake for the divide issue controller.
// master = pipeline (issues operands), slave = div_issue_ctrl.
interface div_issue_ctrl_if;
  logic        ctrl_DIV;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  modport master (
    output ctrl_DIV, data_operandA, data_operandB,
    input  data_result, data_exception, data_resultRDY, busy
  );

  modport slave (
    input  ctrl_DIV, data_operandA, data_operandB,
    output data_result, data_exception, data_resultRDY, busy
  );
endinterface

// File: rtl/div_issue_ctrl.sv
// Sign-handling and sequencing front end for a 32-cycle unsigned restoring divider:
// latches magnitudes, runs the divider, sign-corrects the quotient and stalls the pipe.
module div_issue_ctrl #(
  parameter bit          SIGNED  = 1'b1,
  parameter int unsigned TIMEOUT = 40
) (
  input  logic                   clock,
  input  logic                   reset,
  div_issue_ctrl_if.slave        pipe,
  output logic                   div_reset,
  output logic [31:0]            div_operandA,
  output logic [31:0]            div_operandB,
  input  logic [31:0]            div_result,
  input  logic                   div_resultRDY
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt;
  logic          accept;
  logic          sign_a, sign_b;
  logic          b_zero, b_min, bypass;
  logic          neg;
  logic          timeout;

  assign accept  = pipe.ctrl_DIV && (state != RUN);
  assign sign_a  = SIGNED && pipe.data_operandA[31];
  assign sign_b  = SIGNED && pipe.data_operandB[31];
  assign b_zero  = (pipe.data_operandB == '0);
  // Signed -2^31 divisor has no positive magnitude; quotient is 1 or 0 directly.
  assign b_min   = SIGNED && (pipe.data_operandB == 32'h8000_0000);
  assign bypass  = b_zero || b_min;
  assign timeout = (cnt == CW'(TIMEOUT));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (pipe.ctrl_DIV) state_next = bypass ? DONE : RUN;
      RUN:  if (div_resultRDY || timeout) state_next = DONE;
      DONE: begin
        if (pipe.ctrl_DIV) state_next = bypass ? DONE : RUN;
        else               state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    pipe.busy           = (state == RUN);
    pipe.data_resultRDY = (state == DONE);
  end

  // div_reset is registered from next-state so it is low exactly in RUN cycles.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_reset           <= 1'b1;
      cnt                 <= '0;
      div_operandA        <= '0;
      div_operandB        <= '0;
      neg                 <= 1'b0;
      pipe.data_result    <= '0;
      pipe.data_exception <= 1'b0;
    end else begin
      div_reset <= (state_next != RUN);

      if (state_next == RUN) cnt <= (state == RUN) ? cnt + CW'(1) : CW'(1);
      else                   cnt <= '0;

      if (accept) begin
        div_operandA <= sign_a ? -pipe.data_operandA : pipe.data_operandA;
        div_operandB <= sign_b ? -pipe.data_operandB : pipe.data_operandB;
        neg          <= sign_a ^ sign_b;
        if (b_zero) begin
          pipe.data_result    <= '0;
          pipe.data_exception <= 1'b1;
        end else if (b_min) begin
          pipe.data_result    <= (pipe.data_operandA == 32'h8000_0000) ? 32'd1 : 32'd0;
          pipe.data_exception <= 1'b0;
        end
      end

      if (state == RUN) begin
        if (div_resultRDY) begin
          pipe.data_result    <= neg ? -div_result : div_result;
          pipe.data_exception <= 1'b0;
        end else if (timeout) begin
          pipe.data_result    <= '0;
          pipe.data_exception <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Self-checking bench for div_issue_ctrl: behavioural divide model with per-cycle
// comparison, a stub divider, and directed operations with literal expectations.
module tb_div_issue_ctrl;

  localparam int TIMEOUT = 40;
  localparam bit SIGNED  = 1'b1;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        div_reset;
  logic [31:0] div_operandA, div_operandB;
  logic [31:0] div_result;
  logic        div_resultRDY;
  logic        stall = 1'b0;
  int          timer;

  int n_checks = 0;
  int n_fail   = 0;

  div_issue_ctrl_if pif ();

  div_issue_ctrl #(.SIGNED(SIGNED), .TIMEOUT(TIMEOUT)) dut (
    .clock        (clock),
    .reset        (reset),
    .pipe         (pif),
    .div_reset    (div_reset),
    .div_operandA (div_operandA),
    .div_operandB (div_operandB),
    .div_result   (div_result),
    .div_resultRDY(div_resultRDY)
  );

  always #5 clock = ~clock;

  // Stub divider: timer held at 0 under div_reset, ready when it reaches 31.
  always @(posedge clock) begin
    if (div_reset) timer <= 0;
    else           timer <= timer + 1;
  end
  assign div_resultRDY = !stall && !div_reset && (timer == 31);
  assign div_result    = (div_operandB == 32'd0) ? 32'd0 : div_operandA / div_operandB;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at cycle", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          mcyc = 0;
  int          m_issue = -10, m_done = -1;
  bit          m_run = 0;
  logic [31:0] m_res = '0, m_prev_res = '0, m_opa = '0, m_opb = '0;
  bit          m_exc = 0, m_prev_exc = 0;

  function automatic bit m_busy(input int t);
    return m_run && (t > m_issue) && (t < m_done);
  endfunction

  function automatic logic [31:0] m_cur_res(input int t);
    return (m_done >= 0 && t >= m_done) ? m_res : m_prev_res;
  endfunction

  function automatic bit m_cur_exc(input int t);
    return (m_done >= 0 && t >= m_done) ? m_exc : m_prev_exc;
  endfunction

  task automatic model_accept(input int t, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ma, mb, q;
    int     lat;
    m_prev_res = m_cur_res(t);
    m_prev_exc = m_cur_exc(t);
    sa = SIGNED ? longint'($signed(a)) : longint'(a);
    sb = SIGNED ? longint'($signed(b)) : longint'(b);
    ma = (sa < 0) ? -sa : sa;
    mb = (sb < 0) ? -sb : sb;
    m_opa = ma[31:0];
    m_opb = mb[31:0];
    if (b == 32'd0) begin
      m_res = '0; m_exc = 1; lat = 1;
    end else begin
      q = ma / mb;
      if ((sa < 0) != (sb < 0)) q = -q;
      m_res = q[31:0]; m_exc = 0;
      if (SIGNED && b == 32'h8000_0000) lat = 1;
      else if (stall) begin lat = TIMEOUT + 1; m_res = '0; m_exc = 1; end
      else lat = 33;
    end
    m_issue = t;
    m_done  = t + lat;
    m_run   = (lat > 1);
  endtask

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_issue = -10; m_done = -1; m_run = 0;
      m_res = '0; m_exc = 0; m_prev_res = '0; m_prev_exc = 0;
      m_opa = '0; m_opb = '0;
    end else begin
      if (pif.ctrl_DIV && !m_busy(mcyc))
        model_accept(mcyc, pif.data_operandA, pif.data_operandB);
      mcyc++;
    end
  end

  always @(negedge clock) begin
    bit eb;
    eb = m_busy(mcyc);
    chk("busy",           {31'b0, pif.busy},           {31'b0, eb});
    chk("data_resultRDY", {31'b0, pif.data_resultRDY}, {31'b0, mcyc == m_done});
    chk("div_reset",      {31'b0, div_reset},          {31'b0, !eb});
    chk("data_result",    pif.data_result,             m_cur_res(mcyc));
    chk("data_exception", {31'b0, pif.data_exception}, {31'b0, m_cur_exc(mcyc)});
    chk("div_operandA",   div_operandA,                m_opa);
    chk("div_operandB",   div_operandB,                m_opb);
  end

  // ---------------- directed stimulus ----------------
  task automatic issue(input logic [31:0] a, input logic [31:0] b, output int e0);
    @(posedge clock); #2;
    pif.ctrl_DIV = 1'b1; pif.data_operandA = a; pif.data_operandB = b;
    e0 = mcyc;
    @(posedge clock); #2;
    pif.ctrl_DIV = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int e0, input logic [31:0] er,
                           input bit ee, input int elat, output int busy_n);
    bit seen = 0;
    busy_n = 0;
    for (int i = 0; i < 80 && !seen; i++) begin
      @(negedge clock);
      if (pif.busy) busy_n++;
      if (pif.data_resultRDY) begin
        seen = 1;
        chk({nm, " latency"},   32'(mcyc - e0), 32'(elat));
        chk({nm, " result"},    pif.data_result, er);
        chk({nm, " exception"}, {31'b0, pif.data_exception}, {31'b0, ee});
      end
    end
    if (!seen) begin
      n_checks++; n_fail++;
      $display("FAIL %s ready: got no data_resultRDY expected pulse within 80 cycles", nm);
    end
  endtask

  initial begin
    int e0, e1, bn;
    pif.ctrl_DIV = 1'b0; pif.data_operandA = '0; pif.data_operandB = '0;
    #1 reset = 1'b1;
    @(negedge clock);
    chk("reset data_result", pif.data_result, 32'd0);
    chk("reset div_reset",   {31'b0, div_reset}, 32'd1);
    @(posedge clock); #2 reset = 1'b0;

    issue(32'd100, 32'd7, e0);
    wait_done("100/7", e0, 32'd14, 0, 33, bn);
    chk("100/7 busy cycles", 32'(bn), 32'd32);

    issue(32'hFFFF_FF9C, 32'd7, e0);
    @(negedge clock);
    chk("-100/7 div_operandA", div_operandA, 32'd100);
    wait_done("-100/7", e0, 32'hFFFF_FFF2, 0, 33, bn);

    issue(32'hFFFF_FF9C, 32'hFFFF_FFF9, e0);
    wait_done("-100/-7", e0, 32'd14, 0, 33, bn);

    issue(32'hFFFF_FFF9, 32'd2, e0);
    wait_done("-7/2", e0, 32'hFFFF_FFFD, 0, 33, bn);

    issue(32'd7, 32'd0, e0);
    wait_done("7/0", e0, 32'd0, 1, 1, bn);
    chk("7/0 busy cycles", 32'(bn), 32'd0);

    issue(32'h8000_0000, 32'h8000_0000, e0);
    wait_done("min/min", e0, 32'd1, 0, 1, bn);
    issue(32'd5, 32'h8000_0000, e0);
    wait_done("5/min", e0, 32'd0, 0, 1, bn);

    issue(32'h8000_0000, 32'hFFFF_FFFF, e0);
    wait_done("min/-1", e0, 32'h8000_0000, 0, 33, bn);

    stall = 1'b1;
    issue(32'd100, 32'd7, e0);
    wait_done("timeout", e0, 32'd0, 1, TIMEOUT + 1, bn);
    @(posedge clock); #2 stall = 1'b0;

    issue(32'd100, 32'd7, e0);
    repeat (9) @(posedge clock);
    #2 reset = 1'b1;
    @(negedge clock);
    chk("midreset busy",   {31'b0, pif.busy}, 32'd0);
    chk("midreset rdy",    {31'b0, pif.data_resultRDY}, 32'd0);
    chk("midreset result", pif.data_result, 32'd0);
    chk("midreset div_reset", {31'b0, div_reset}, 32'd1);
    @(posedge clock); #2 reset = 1'b0;
    repeat (30) @(posedge clock);

    issue(32'd9, 32'd3, e0);
    wait_done("9/3", e0, 32'd3, 0, 33, bn);

    issue(32'd100, 32'd7, e0);
    wait_done("b2b first", e0, 32'd14, 0, 33, bn);
    pif.ctrl_DIV = 1'b1; pif.data_operandA = 32'd50; pif.data_operandB = 32'd5;
    e1 = mcyc;
    @(posedge clock); #2 pif.ctrl_DIV = 1'b0;
    wait_done("b2b 50/5", e1, 32'd10, 0, 33, bn);

    repeat (3) @(posedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1);
  end

endmodule

// File: doc/div_issue_ctrl.md
# div_issue_ctrl

Sequencing and sign-handling front end for the 32-cycle unsigned restoring divider in the execute stage. Latches operands on a divide issue, converts them to magnitudes and holds them stable for the divider. Resets and starts the divider, waits for its ready strobe, and applies quotient sign correction. Returns a registered result with a one-cycle ready pulse, and drives a busy/stall line to the pipeline for the whole operation.

## Interface
- SIGNED, 1, 1 = two's-complement divide with sign correction; 0 = operands passed through unsigned
- TIMEOUT, 40, RUN cycles allowed before aborting with exception (must be ≥ 33)
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- ctrl_DIV  in  1  issue strobe; sampled on rising edge when accepted
- data_operandA  in  32  dividend
- data_operandB  in  32  divisor
- data_result  out  32  registered quotient
- data_exception  out  1  divide-by-zero or timeout, valid with data_resultRDY
- data_resultRDY  out  1  one-cycle completion pulse
- busy  out  1  pipeline stall; high from issue until the cycle before data_resultRDY
- div_reset  out  1  registered reset to divider; high except in RUN
- div_operandA, div_operandB  out  32  held magnitudes to divider
- div_result  in  32  divider quotient (combinational from divider)
- div_resultRDY  in  1  divider ready (timer == 31)

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE.
- Accept: ctrl_DIV = 1 in IDLE or DONE. Ignored in RUN.
- On accept:
  - latch sA = A[31], sB = B[31] (forced 0 if SIGNED = 0)
  - div_operandA = sA ? −A : A; div_operandB = sB ? −B : B
  - neg = sA ^ sB
- Bypass cases (divider not started), go to DONE:
  - B == 0: result 0, exception 1
  - SIGNED = 1 and B == 0x80000000: result = (A == 0x80000000) ? 1 : 0, exception 0
- Otherwise go to RUN. div_reset deasserts and the divider timer starts at 0.
- RUN:
  - cycle counter cnt starts at 1 on the first RUN cycle and increments each cycle
  - on div_resultRDY = 1: capture q = neg ? −div_result : div_result into data_result, exception 0, go to DONE
  - if cnt == TIMEOUT without div_resultRDY: data_result = 0, exception 1, go to DONE
- DONE: data_resultRDY = 1 for exactly one cycle. data_result and data_exception hold until the next completion or reset. Next state is RUN/DONE on a new accept, else IDLE.
- Arithmetic:
  - all negation is 32-bit two's complement, wraparound
  - 0x80000000 / −1 yields 0x80000000 with exception 0
  - remainder is not produced

## Timing
- Reset values:
  - data_result = 0; data_exception = 0; data_resultRDY = 0; busy = 0
  - div_reset = 1; div_operandA = div_operandB = 0; state IDLE; cnt = 0
- Normal latency: ctrl_DIV sampled at edge E0.
  - RUN occupies cycles E0+1 … E0+32; div_resultRDY is seen in cycle E0+32
  - data_resultRDY is high in cycle E0+33
- Bypass latency: data_resultRDY is high in cycle E0+1.
- busy is high in every RUN cycle and low in IDLE/DONE. Issue and completion can coincide, giving back-to-back issues with no gap.
- div_operandA/B are stable during all RUN cycles, because the divider's cycle-0 step reads them directly.
- div_reset is high in the same cycle the state is IDLE/DONE, since it is driven from registered state. This guarantees the divider timer reads 0 in the first RUN cycle.
- Reset mid-RUN: state returns to IDLE asynchronously, div_reset goes to 1, no data_resultRDY is produced, and outputs take their reset values.
- A ctrl_DIV that arrives in the same cycle as the DONE pulse is accepted. The new operands are latched and data_result updates only at the next completion.

## Test plan
- A = 100, B = 7 → data_resultRDY at E0+33, data_result = 14, exception 0, busy high for exactly 32 cycles.
- A = −100 (0xFFFFFF9C), B = 7 → div_operandA = 100, data_result = 0xFFFFFFF2 (−14); A = −100, B = −7 → 14.
- A = 7, B = 0 → data_resultRDY at E0+1, data_result = 0, exception 1, div_reset stays 1, busy never high.
- B = 0x80000000 with A = 0x80000000 → result 1; with A = 5 → result 0; both at E0+1, exception 0.
- div_resultRDY tied low → exception 1, data_result = 0, data_resultRDY in cycle E0+TIMEOUT+1.
- Assert reset at E0+10 of a 100/7 divide → no ready pulse, all outputs at reset values. Then issue 9/3 → result 3 at 33 cycles after its issue. Also issue 50/5 in the DONE cycle of a prior divide → back-to-back result 10.
